// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: funct3 codes, FSM states,
// the registered command record and access-size helpers.
package lsu_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [2:0]            funct3;
    logic                  write;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_cmd_t;

  // Byte mask of the access before lane shifting; the unsigned forms share the signed sizes.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [3:0] mode);
    if (mode[0]) return mode[3:1] inside {F3_B, F3_H, F3_W};
    return mode[3:1] inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic access_split(input logic [2:0] f3, input logic [1:0] off);
    return ({1'b0, off} + size_bytes(f3)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and write data for both beats,
// and the shifted, sign/zero-extended load result from the 64-bit assembly word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] asm_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  be_o,
  output logic [63:0] wdat_o
);

  logic [31:0] sh_rd;

  always_comb begin
    be_o   = {4'h0, size_mask(funct3_i)} << off_i;
    wdat_o = {32'h0, wdata_i} << {off_i, 3'b000};
    sh_rd  = 32'(asm_i >> {off_i, 3'b000});
    rdata_o = sh_rd;
    case (funct3_i)
      F3_B:    rdata_o = {{24{sh_rd[7]}}, sh_rd[7:0]};
      F3_H:    rdata_o = {{16{sh_rd[15]}}, sh_rd[15:0]};
      F3_BU:   rdata_o = {24'h0, sh_rd[7:0]};
      F3_HU:   rdata_o = {16'h0, sh_rd[15:0]};
      default: rdata_o = sh_rd;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store executor on a req/ack word bus; LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two beats.
// Latency accept->rsp: 1 (error), 2 + ack waits (single beat), 4 + ack waits (split); req_ready only while idle.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        ram_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_e  state_q, state_d;
  lsu_cmd_t    cmd_q, cmd_d;
  logic        err_q, err_d;
  logic [63:0] asm_q, asm_d;

  logic [31:0] align_rdata;
  logic [7:0]  be8;
  logic [63:0] wdat64;

`ifdef LSU_MISALIGN_SPLIT_EN
  // Forces the idle bus cycle between the two beats of a split access.
  logic gap_q, gap_d;
`else
  logic unused_beat1;
  assign unused_beat1 = ^{be8[7:4], wdat64[63:32]};
`endif

  lsu_lane_align u_align (
    .off_i    (cmd_q.addr[1:0]),
    .funct3_i (cmd_q.funct3),
    .wdata_i  (cmd_q.wdata),
    .asm_i    (asm_q),
    .rdata_o  (align_rdata),
    .be_o     (be8),
    .wdat_o   (wdat64)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    err_d     = err_q;
    asm_d     = asm_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    gap_d     = 1'b0;
`endif
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rdata     = '0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'h0;
    bus_wdata = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_d.funct3 = ram_mode[3:1];
          cmd_d.write  = ram_mode[0];
          cmd_d.addr   = addr;
          cmd_d.wdata  = wdata;
          err_d        = !mode_legal(ram_mode) ||
                         (!SPLIT_EN && access_split(ram_mode[3:1], addr[1:0]));
          asm_d        = '0;
          state_d      = err_d ? RESP : ACC0;
        end
      end

      ACC0: begin
        bus_req   = 1'b1;
        bus_we    = cmd_q.write;
        bus_addr  = {cmd_q.addr[ADDR_W-1:2], 2'b00};
        bus_be    = be8[3:0];
        bus_wdata = wdat64[31:0];
        if (bus_ack) begin
          asm_d   = {32'h0, bus_rdata};
          state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (|be8[7:4]) begin
            state_d = ACC1;
            gap_d   = 1'b1;
          end
`endif
        end
      end

`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        bus_req   = !gap_q;
        bus_we    = cmd_q.write;
        bus_addr  = {cmd_q.addr[ADDR_W-1:2] + 30'd1, 2'b00};
        bus_be    = be8[7:4];
        bus_wdata = wdat64[63:32];
        if (bus_ack && !gap_q) begin
          asm_d[63:32] = bus_rdata;
          state_d      = RESP;
        end
      end
`endif

      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rdata     = (err_q || cmd_q.write) ? '0 : align_rdata;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      err_q   <= 1'b0;
      asm_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      gap_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      asm_q   <= asm_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      gap_q   <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: bus responder checks each beat, response monitor checks data and timing.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  ram_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_mem_port dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .ram_mode  (ram_mode),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Bus responder: checks each new beat, holds it for the programmed waits, then acks.
  initial begin : responder
    logic     in_txn;
    logic     prev_ack;
    int       wl;
    bus_exp_t cur;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    in_txn = 1'b0; prev_ack = 1'b0; wl = 0;
    bus_ack = 1'b0; bus_rdata = 32'hDEAD_DEAD;
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'hDEAD_DEAD;
      if (rst) begin
        in_txn = 1'b0; prev_ack = 1'b0;
      end else begin
        if (prev_ack) chk("bus_gap_after_ack", 32'(bus_req), 32'd0);
        prev_ack = 1'b0;
        if (bus_req) begin
          if (!in_txn) begin
            if (bus_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_bus_req: addr 0x%08h be %b with no beat expected", bus_addr, bus_be);
              bus_ack = 1'b1;
              prev_ack = 1'b1;
            end else begin
              cur = bus_q.pop_front();
              chk("bus_we", 32'(bus_we), 32'(cur.we));
              chk("bus_addr", bus_addr, cur.addr);
              chk("bus_be", 32'(bus_be), 32'(cur.be));
              if (cur.we) chk("bus_wdata", bus_wdata & lane_mask(cur.be), cur.wdata);
              s_we = bus_we; s_addr = bus_addr; s_be = bus_be; s_wd = bus_wdata;
              wl = cur.waits;
              in_txn = 1'b1;
            end
          end else begin
            chk("bus_stable_we", 32'(bus_we), 32'(s_we));
            chk("bus_stable_addr", bus_addr, s_addr);
            chk("bus_stable_be", 32'(bus_be), 32'(s_be));
            chk("bus_stable_wdata", bus_wdata, s_wd);
          end
          if (in_txn) begin
            if (wl == 0) begin
              bus_ack = 1'b1; bus_rdata = cur.rdata;
              in_txn = 1'b0; prev_ack = 1'b1;
            end else begin
              wl--;
            end
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin : rsp_monitor
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 err=%0b rdata=0x%08h with nothing outstanding", rsp_err, rdata);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", rdata, e.rdata);
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int waits, input logic [31:0] rd);
    bus_exp_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd; b.waits = waits; b.rdata = rd;
    bus_q.push_back(b);
  endtask

  task automatic issue(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input int lat, input bit push_rsp);
    rsp_exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL req_ready_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, guard);
      return;
    end
    req_valid = 1'b1; ram_mode = mode; addr = a; wdata = wd;
    if (push_rsp) begin
      e.err = exp_err; e.rdata = exp_rd; e.cyc = cyc + lat;
      rsp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0; ram_mode = 4'b0100; addr = 32'hFFFF_FFFF; wdata = 32'hA5A5_A5A5;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (rsp_q.size() != 0 || bus_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d responses and %0d beats outstanding, required 0", rsp_q.size(), bus_q.size());
      rsp_q.delete();
      bus_q.delete();
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; req_valid = 1'b0; ram_mode = 4'h0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // lb 0x1003: byte 0x80 sign-extends
    exp_bus(1'b0, 32'h0000_1000, 4'b1000, 32'h0, 0, 32'h80FF_0000);
    issue(4'b0000, 32'h0000_1003, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 1'b1);
    drain();

    // sh 0x2002 with 3 ack waits
    exp_bus(1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_0000, 3, 32'h0);
    issue(4'b0011, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 32'h0, 5, 1'b1);
    drain();

`ifdef LSU_MISALIGN_SPLIT_EN
    // lw 0x0FFFFFFD split across two words
    exp_bus(1'b0, 32'h0FFF_FFFC, 4'b1110, 32'h0, 0, 32'hAABB_CCDD);
    exp_bus(1'b0, 32'h1000_0000, 4'b0001, 32'h0, 0, 32'h1122_3344);
    issue(4'b0100, 32'h0FFF_FFFD, 32'h0, 1'b0, 32'h44AA_BBCC, 4, 1'b1);
    drain();

    // sw 0xFFFFFFFE wraps to address 0 for the second beat
    exp_bus(1'b1, 32'hFFFF_FFFC, 4'b1100, 32'h5678_0000, 0, 32'h0);
    exp_bus(1'b1, 32'h0000_0000, 4'b0011, 32'h0000_1234, 1, 32'h0);
    issue(4'b0101, 32'hFFFF_FFFE, 32'h1234_5678, 1'b0, 32'h0, 5, 1'b1);
    drain();

    // lh 0x6003 split, second beat waits 2
    exp_bus(1'b0, 32'h0000_6000, 4'b1000, 32'h0, 0, 32'hAB11_2233);
    exp_bus(1'b0, 32'h0000_6004, 4'b0001, 32'h0, 2, 32'h4455_66CD);
    issue(4'b0010, 32'h0000_6003, 32'h0, 1'b0, 32'hFFFF_CDAB, 6, 1'b1);
    drain();
`else
    // misaligned accesses rejected without bus activity
    issue(4'b0100, 32'h0FFF_FFFD, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    drain();
    issue(4'b0101, 32'hFFFF_FFFE, 32'h1234_5678, 1'b1, 32'h0, 1, 1'b1);
    drain();
    issue(4'b0010, 32'h0000_6003, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    drain();
`endif

    // illegal store funct3 011 and illegal load funct3 011
    issue(4'b0111, 32'h0000_0100, 32'h1, 1'b1, 32'h0, 1, 1'b1);
    drain();
    issue(4'b0110, 32'h0000_0100, 32'h0, 1'b1, 32'h0, 1, 1'b1);
    drain();

    // lhu / lh at offset 2, one wait each
    exp_bus(1'b0, 32'h0000_3000, 4'b1100, 32'h0, 1, 32'h8001_0000);
    issue(4'b1010, 32'h0000_3002, 32'h0, 1'b0, 32'h0000_8001, 3, 1'b1);
    drain();
    exp_bus(1'b0, 32'h0000_3000, 4'b1100, 32'h0, 1, 32'h8001_0000);
    issue(4'b0010, 32'h0000_3002, 32'h0, 1'b0, 32'hFFFF_8001, 3, 1'b1);
    drain();

    // aligned lw, sb, sw
    exp_bus(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF);
    issue(4'b0100, 32'h0000_4000, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);
    drain();
    exp_bus(1'b1, 32'h0000_5000, 4'b0010, 32'h0000_A500, 0, 32'h0);
    issue(4'b0001, 32'h0000_5001, 32'h0000_00A5, 1'b0, 32'h0, 2, 1'b1);
    drain();
    exp_bus(1'b1, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 2, 32'h0);
    issue(4'b0101, 32'h0000_7000, 32'hCAFE_F00D, 1'b0, 32'h0, 4, 1'b1);
    drain();

    // reset while waiting on ack: transaction abandoned, no response
    exp_bus(1'b0, 32'h0000_8000, 4'b1111, 32'h0, 20, 32'h0);
    issue(4'b0100, 32'h0000_8000, 32'h0, 1'b0, 32'h0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_q.delete();
    repeat (3) @(negedge clk);

    // lbu 0x1 after reset: zero-extended byte
    exp_bus(1'b0, 32'h0000_0000, 4'b0010, 32'h0, 0, 32'h0000_F100);
    issue(4'b1000, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_00F1, 2, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    chk("final_rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    chk("final_bus_queue_empty", 32'(bus_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
